// File: rtl/dma_int_status_queue_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dma_int_status_queue_if : status-word, pop/clear and head-entry signals
// Rev 1.0
// ---------------------------------------------------------------------------
interface dma_int_status_queue_if #(
  parameter int NUM_INT_BDS_WIDTH = 2,
  parameter int FIFO_DEPTH_WIDTH  = 2
);
  logic                         valid;
  logic                         opDone;
  logic                         wrError;
  logic                         rdError;
  logic                         dscrptrNValidError;
  logic [NUM_INT_BDS_WIDTH-1:0] intDscrptrNum;
  logic                         extDscrptr;
  logic                         strDscrptr;
  logic [31:0]                  extDscrptrAddr;
  logic [3:0]                   evtEnable;
  logic                         popReq;
  logic                         clrOverflow;

  logic                         headOpDone;
  logic                         headWrError;
  logic                         headRdError;
  logic                         headNValidError;
  logic [NUM_INT_BDS_WIDTH-1:0] headIntDscrptrNum;
  logic                         headExtDscrptr;
  logic                         headStrDscrptr;
  logic [31:0]                  headExtDscrptrAddr;
  logic                         empty;
  logic                         full;
  logic [FIFO_DEPTH_WIDTH:0]    count;
  logic                         overflow;
  logic                         irq;

  modport master (
    output valid, opDone, wrError, rdError, dscrptrNValidError, intDscrptrNum,
           extDscrptr, strDscrptr, extDscrptrAddr, evtEnable, popReq, clrOverflow,
    input  headOpDone, headWrError, headRdError, headNValidError, headIntDscrptrNum,
           headExtDscrptr, headStrDscrptr, headExtDscrptrAddr, empty, full, count,
           overflow, irq
  );

  modport slave (
    input  valid, opDone, wrError, rdError, dscrptrNValidError, intDscrptrNum,
           extDscrptr, strDscrptr, extDscrptrAddr, evtEnable, popReq, clrOverflow,
    output headOpDone, headWrError, headRdError, headNValidError, headIntDscrptrNum,
           headExtDscrptr, headStrDscrptr, headExtDscrptrAddr, empty, full, count,
           overflow, irq
  );
endinterface
`default_nettype wire

// File: rtl/dma_int_status_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dma_int_status_queue : filtered DMA interrupt status FIFO with level irq
// Rev 1.0
// ---------------------------------------------------------------------------
module dma_int_status_queue #(
  parameter int NUM_INT_BDS_WIDTH = 2,
  parameter int FIFO_DEPTH        = 4,
  parameter int FIFO_DEPTH_WIDTH  = 2
) (
  input  wire logic              clock,
  input  wire logic              reset,
  dma_int_status_queue_if.slave  bus
);
  localparam int CW = FIFO_DEPTH_WIDTH + 1;
  localparam int WW = 4 + NUM_INT_BDS_WIDTH + 2 + 32;
  localparam logic [CW-1:0] c_full_count = CW'(FIFO_DEPTH);

  logic [WW-1:0]               r_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH_WIDTH-1:0] r_wrPtr;
  logic [FIFO_DEPTH_WIDTH-1:0] r_rdPtr;
  logic [CW-1:0]               r_count;
  logic                        r_overflow;
  logic                        r_irq;

  logic          w_accept;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [CW-1:0] w_count_next;
  logic          w_overflow_next;
  logic [WW-1:0] w_wdata;
  logic [WW-1:0] w_head;

  assign w_accept = bus.valid & ((bus.opDone & bus.evtEnable[0]) |
                                 (bus.wrError & bus.evtEnable[1]) |
                                 (bus.rdError & bus.evtEnable[2]) |
                                 (bus.dscrptrNValidError & bus.evtEnable[3]));
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == c_full_count);
  assign w_pop    = bus.popReq & ~w_empty;
  // A pop frees a slot in the same cycle, so a full queue still accepts.
  assign w_push   = w_accept & (~w_full | w_pop);
  assign w_drop   = w_accept & w_full & ~w_pop;

  assign w_count_next    = r_count + CW'(w_push) - CW'(w_pop);
  assign w_overflow_next = w_drop | (r_overflow & ~bus.clrOverflow);

  assign w_wdata = {bus.dscrptrNValidError, bus.rdError, bus.wrError, bus.opDone,
                    bus.intDscrptrNum, bus.extDscrptr, bus.strDscrptr, bus.extDscrptrAddr};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      r_count    <= w_count_next;
      r_overflow <= w_overflow_next;
      r_irq      <= (w_count_next != '0) | w_overflow_next;
    end
  end

  // Storage has no reset; contents are only observed through r_rdPtr when non-empty.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wrPtr] <= w_wdata;
  end

  assign w_head = w_empty ? '0 : r_mem[r_rdPtr];

  assign {bus.headNValidError, bus.headRdError, bus.headWrError, bus.headOpDone,
          bus.headIntDscrptrNum, bus.headExtDscrptr, bus.headStrDscrptr,
          bus.headExtDscrptrAddr} = w_head;

  assign bus.empty    = w_empty;
  assign bus.full     = w_full;
  assign bus.count    = r_count;
  assign bus.overflow = r_overflow;
  assign bus.irq      = r_irq;
endmodule
`default_nettype wire

// File: tb/tb_dma_int_status_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dma_int_status_queue : scenario tasks plus randomized run vs queue model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_dma_int_status_queue;
  localparam int NB    = 2;
  localparam int DEPTH = 4;
  localparam int DW    = 2;
  localparam int OW    = 4 + NB + 2 + 32 + 2 + (DW + 1) + 2;

  typedef struct packed {
    logic [3:0]    ev;   // {nvalid, rd, wr, opDone}
    logic [NB-1:0] num;
    logic          ext;
    logic          str;
    logic [31:0]   addr;
  } word_t;

  logic clock;
  logic reset;
  dma_int_status_queue_if #(.NUM_INT_BDS_WIDTH(NB), .FIFO_DEPTH_WIDTH(DW)) bus ();

  dma_int_status_queue #(
    .NUM_INT_BDS_WIDTH(NB), .FIFO_DEPTH(DEPTH), .FIFO_DEPTH_WIDTH(DW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int    n_checks = 0;
  int    n_fail   = 0;
  word_t q[$];
  logic  m_ov  = 1'b0;
  logic  m_irq = 1'b0;

  // Reference: a plain queue of accepted words plus a sticky overflow bit.
  function automatic void model_update();
    logic  acc, pop, drop;
    word_t w;
    if (reset) begin
      q.delete();
      m_ov  = 1'b0;
      m_irq = 1'b0;
      return;
    end
    acc  = bus.valid && ((bus.opDone && bus.evtEnable[0]) || (bus.wrError && bus.evtEnable[1]) ||
                         (bus.rdError && bus.evtEnable[2]) || (bus.dscrptrNValidError && bus.evtEnable[3]));
    pop  = bus.popReq && (q.size() > 0);
    drop = acc && (q.size() == DEPTH) && !pop;
    if (pop) void'(q.pop_front());
    if (acc && !drop) begin
      w.ev   = {bus.dscrptrNValidError, bus.rdError, bus.wrError, bus.opDone};
      w.num  = bus.intDscrptrNum;
      w.ext  = bus.extDscrptr;
      w.str  = bus.strDscrptr;
      w.addr = bus.extDscrptrAddr;
      q.push_back(w);
    end
    m_ov  = drop || (m_ov && !bus.clrOverflow);
    m_irq = (q.size() != 0) || m_ov;
  endfunction

  function automatic logic [OW-1:0] expected_vec();
    word_t h;
    h = (q.size() > 0) ? q[0] : '0;
    return {h, (q.size() == 0), (q.size() == DEPTH), (DW+1)'(q.size()), m_ov, m_irq};
  endfunction

  function automatic logic [OW-1:0] observed_vec();
    return {bus.headNValidError, bus.headRdError, bus.headWrError, bus.headOpDone,
            bus.headIntDscrptrNum, bus.headExtDscrptr, bus.headStrDscrptr, bus.headExtDscrptrAddr,
            bus.empty, bus.full, bus.count, bus.overflow, bus.irq};
  endfunction

  task automatic tick();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    bus.valid = 0; bus.opDone = 0; bus.wrError = 0; bus.rdError = 0;
    bus.dscrptrNValidError = 0; bus.intDscrptrNum = '0; bus.extDscrptr = 0;
    bus.strDscrptr = 0; bus.extDscrptrAddr = '0; bus.popReq = 0; bus.clrOverflow = 0;
  endtask

  task automatic drive_word(input word_t w);
    bus.valid = 1;
    {bus.dscrptrNValidError, bus.rdError, bus.wrError, bus.opDone} = w.ev;
    bus.intDscrptrNum = w.num; bus.extDscrptr = w.ext;
    bus.strDscrptr = w.str; bus.extDscrptrAddr = w.addr;
  endtask

  function automatic word_t rand_word(input logic [3:0] ev);
    word_t w;
    w.ev = ev; w.num = NB'($urandom); w.ext = 1'($urandom);
    w.str = 1'($urandom); w.addr = $urandom;
    return w;
  endfunction

  task automatic test_reset();
    idle_inputs(); bus.evtEnable = 4'hF;
    reset = 1; tick(); reset = 0;
    n_checks++;
    if (observed_vec() !== expected_vec()) begin
      n_fail++; $display("FAIL reset_state: got %h expected %h", observed_vec(), expected_vec());
    end
    n_checks++;
    if ({bus.empty, bus.full, bus.count, bus.irq, bus.overflow} !== {1'b1, 1'b0, 3'd0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 1000000", {bus.empty, bus.full, bus.count, bus.irq, bus.overflow});
    end
  endtask

  task automatic test_basic();
    word_t w;
    w = '0; w.ev = 4'b0001; w.num = 2'd2; w.addr = 32'h1000_0040;
    bus.evtEnable = 4'hF;
    drive_word(w); tick(); idle_inputs();
    n_checks++;
    if ({bus.count, bus.empty, bus.headIntDscrptrNum, bus.headExtDscrptrAddr, bus.irq} !==
        {3'd1, 1'b0, 2'd2, 32'h1000_0040, 1'b1}) begin
      n_fail++; $display("FAIL basic_push: got cnt=%0d empty=%b num=%0d addr=%h irq=%b expected cnt=1 empty=0 num=2 addr=10000040 irq=1",
                         bus.count, bus.empty, bus.headIntDscrptrNum, bus.headExtDscrptrAddr, bus.irq);
    end
    bus.popReq = 1; tick(); bus.popReq = 0;
    n_checks++;
    if ({bus.count, bus.irq} !== {3'd0, 1'b0}) begin
      n_fail++; $display("FAIL basic_pop: got cnt=%0d irq=%b expected cnt=0 irq=0", bus.count, bus.irq);
    end
  endtask

  task automatic test_filter();
    bus.evtEnable = 4'b0001;
    drive_word(rand_word(4'b0010)); tick(); idle_inputs();
    n_checks++;
    if ({bus.count, bus.overflow, bus.irq} !== {3'd0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL filter_drop: got cnt=%0d ov=%b irq=%b expected 0 0 0", bus.count, bus.overflow, bus.irq);
    end
    drive_word(rand_word(4'b0001)); tick(); idle_inputs();
    n_checks++;
    if (bus.count !== 3'd1 || observed_vec() !== expected_vec()) begin
      n_fail++; $display("FAIL filter_accept: got %h expected %h", observed_vec(), expected_vec());
    end
    bus.popReq = 1; tick(); idle_inputs();
  endtask

  task automatic test_overflow();
    bus.evtEnable = 4'hF;
    for (int i = 0; i < 5; i++) begin
      drive_word(rand_word(4'($urandom_range(1, 15)))); tick();
      n_checks++;
      if (observed_vec() !== expected_vec()) begin
        n_fail++; $display("FAIL overflow_fill%0d: got %h expected %h", i, observed_vec(), expected_vec());
      end
    end
    idle_inputs();
    n_checks++;
    if ({bus.full, bus.overflow, bus.irq, bus.count} !== {1'b1, 1'b1, 1'b1, 3'd4}) begin
      n_fail++; $display("FAIL overflow_flags: got full=%b ov=%b irq=%b cnt=%0d expected 1 1 1 4", bus.full, bus.overflow, bus.irq, bus.count);
    end
    for (int i = 0; i < 4; i++) begin
      bus.popReq = 1; tick();
      n_checks++;
      if (observed_vec() !== expected_vec()) begin
        n_fail++; $display("FAIL overflow_pop%0d: got %h expected %h", i, observed_vec(), expected_vec());
      end
    end
    idle_inputs();
    n_checks++;
    if ({bus.empty, bus.irq} !== 2'b11) begin
      n_fail++; $display("FAIL overflow_irq_held: got empty=%b irq=%b expected 1 1", bus.empty, bus.irq);
    end
    bus.clrOverflow = 1; tick(); idle_inputs();
    n_checks++;
    if ({bus.overflow, bus.irq} !== 2'b00) begin
      n_fail++; $display("FAIL overflow_clear: got ov=%b irq=%b expected 0 0", bus.overflow, bus.irq);
    end
  endtask

  task automatic test_full_push_pop();
    bus.evtEnable = 4'hF;
    for (int i = 0; i < 4; i++) begin drive_word(rand_word(4'b0001)); tick(); end
    drive_word(rand_word(4'b0100)); bus.popReq = 1; tick(); idle_inputs();
    n_checks++;
    if ({bus.count, bus.overflow} !== {3'd4, 1'b0} || observed_vec() !== expected_vec()) begin
      n_fail++; $display("FAIL full_push_pop: got %h expected %h", observed_vec(), expected_vec());
    end
    for (int i = 0; i < 4; i++) begin
      bus.popReq = 1; tick();
      n_checks++;
      if (observed_vec() !== expected_vec()) begin
        n_fail++; $display("FAIL full_drain%0d: got %h expected %h", i, observed_vec(), expected_vec());
      end
    end
    idle_inputs();
  endtask

  task automatic test_empty_pop();
    bus.popReq = 1; tick(); idle_inputs();
    n_checks++;
    if ({bus.count, bus.empty} !== {3'd0, 1'b1}) begin
      n_fail++; $display("FAIL empty_pop: got cnt=%0d empty=%b expected 0 1", bus.count, bus.empty);
    end
    drive_word(rand_word(4'b1000)); tick(); idle_inputs();
    n_checks++;
    if (observed_vec() !== expected_vec()) begin
      n_fail++; $display("FAIL empty_pop_push: got %h expected %h", observed_vec(), expected_vec());
    end
    bus.popReq = 1; tick(); idle_inputs();
    n_checks++;
    if (observed_vec() !== expected_vec()) begin
      n_fail++; $display("FAIL empty_pop_drain: got %h expected %h", observed_vec(), expected_vec());
    end
  endtask

  task automatic test_mid_reset();
    bus.evtEnable = 4'hF;
    for (int i = 0; i < 5; i++) begin drive_word(rand_word(4'b0011)); tick(); end
    idle_inputs(); bus.popReq = 1; tick(); idle_inputs();
    n_checks++;
    if ({bus.count, bus.overflow} !== {3'd3, 1'b1}) begin
      n_fail++; $display("FAIL mid_reset_setup: got cnt=%0d ov=%b expected 3 1", bus.count, bus.overflow);
    end
    reset = 1; tick(); reset = 0;
    n_checks++;
    if (observed_vec() !== {(OW-9)'(0), 1'b1, 1'b0, 3'd0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL mid_reset: got %h expected cleared/empty", observed_vec());
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      if (c % 16 == 0) bus.evtEnable = 4'($urandom);
      if ($urandom_range(0, 1) == 1) drive_word(rand_word(4'($urandom)));
      else bus.valid = 0;
      bus.popReq      = ($urandom_range(0, 2) == 0);
      bus.clrOverflow = ($urandom_range(0, 9) == 0);
      reset           = ($urandom_range(0, 149) == 0);
      tick();
      reset = 0;
      n_checks++;
      if (observed_vec() !== expected_vec()) begin
        n_fail++; $display("FAIL random cyc=%0d: got %h expected %h", c, observed_vec(), expected_vec());
      end
    end
    idle_inputs();
  endtask

  initial begin
    reset = 0;
    idle_inputs();
    bus.evtEnable = 4'hF;
    test_reset();
    test_basic();
    test_filter();
    test_overflow();
    test_full_push_pop();
    test_empty_pop();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/dma_int_status_queue.md
Name: dma_int_status_queue

Overview:
- Consumer end of the DMA interrupt status path.
- Accepts one status word per cycle from the interrupt status multiplexer's valid/field outputs. That interface has no back-pressure; the multiplexer acks its sources in the same cycle.
- Filters each word through per-event enables and buffers it in a small FIFO.
- Drives a level interrupt towards the host; the register block reads and pops entries.

Parameters:
- NUM_INT_BDS_WIDTH, 2, width of internal descriptor number field.
- FIFO_DEPTH, 4, number of status entries held; power of two, min 2.
- FIFO_DEPTH_WIDTH, 2, log2(FIFO_DEPTH); pointer width. Count width is FIFO_DEPTH_WIDTH+1.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- valid  in  1  status word present this cycle; no ready returned.
- opDone  in  1  transfer completed.
- wrError  in  1  write error.
- rdError  in  1  read error.
- dscrptrNValidError  in  1  descriptor not-valid error.
- intDscrptrNum  in  NUM_INT_BDS_WIDTH  internal descriptor number.
- extDscrptr  in  1  external descriptor flag.
- strDscrptr  in  1  stream descriptor flag.
- extDscrptrAddr  in  32  external descriptor address.
- evtEnable  in  4  {dscrptrNValidErr, rdErr, wrErr, opDone} enables.
- popReq  in  1  register block pops head entry (one-cycle pulse).
- clrOverflow  in  1  clear sticky overflow.
- headOpDone, headWrError, headRdError, headNValidError  out  1 each  head entry event bits.
- headIntDscrptrNum  out  NUM_INT_BDS_WIDTH  head descriptor number.
- headExtDscrptr, headStrDscrptr  out  1 each  head descriptor flags.
- headExtDscrptrAddr  out  32  head external address.
- empty  out  1  queue empty.
- full  out  1  queue full.
- count  out  FIFO_DEPTH_WIDTH+1  occupied entries.
- overflow  out  1  sticky: an enabled word was dropped.
- irq  out  1  level interrupt, registered.

Behaviour:
- Reset, synchronous, active-high:
  - Pointers, count and overflow are 0; irq is 0.
  - empty=1, full=0.
  - All head outputs are 0.
  - Storage contents are don't-care.
- Accept condition:
  - accept = valid & ((opDone&evtEnable[0]) | (wrError&evtEnable[1]) | (rdError&evtEnable[2]) | (dscrptrNValidError&evtEnable[3])).
  - A valid word with no enabled event is discarded silently; no count or overflow change.
- Push:
  - Occurs if accept & (!full | pop).
  - The whole word (all fields) is written at wrPtr; wrPtr increments modulo FIFO_DEPTH.
- Pop:
  - pop = popReq & !empty; popReq while empty is ignored.
  - rdPtr increments modulo FIFO_DEPTH.
- Simultaneous push and pop:
  - count is unchanged, including when full; the full-and-pop case is not an overflow.
  - When count==1, the new word becomes head the cycle after.
- Overflow:
  - accept & full & !pop drops the word and sets overflow=1 next cycle.
  - overflow holds until clrOverflow. If clrOverflow coincides with a new drop, overflow stays 1 (set wins).
- Count:
  - count = count + push - pop.
  - empty = (count==0); full = (count==FIFO_DEPTH). Both are derived from the registered count.
- Head outputs:
  - Combinational from the entry at rdPtr when !empty; forced to 0 when empty.
  - A pushed word is visible on head outputs one cycle after valid (latency 1).
- irq:
  - Registered: irq <= (count_next != 0) | overflow_next.
  - Rises one cycle after the first accepted push.
  - Falls the cycle after the pop that empties the queue, provided overflow is clear.
- No handshake exists towards the multiplexer. The block never stalls, and every cycle's valid is evaluated independently.
- reset asserted mid-operation discards all entries and clears irq/overflow the next edge.

Test Plan:
- Reset, then evtEnable=4'hF, one valid word {opDone=1, intDscrptrNum=2, extDscrptrAddr=32'h1000_0040} -> next cycle count=1, empty=0, headIntDscrptrNum=2, headExtDscrptrAddr=32'h1000_0040, irq=1. popReq for one cycle -> count=0, irq=0 the following cycle.
- evtEnable=4'b0001, valid word {wrError=1 only} -> dropped: count stays 0, overflow=0, irq=0. Then {opDone=1} -> accepted, count=1.
- Five enabled words on consecutive cycles with FIFO_DEPTH=4 -> full=1 after the 4th, 5th dropped, overflow=1, irq=1. Pops return words 1-4 in order. After the last pop irq stays 1 until clrOverflow, then drops to 0.
- Queue full plus valid enabled word and popReq in the same cycle -> count stays 4, overflow stays 0. Head advances to entry 2, and the new word is read out 4th.
- popReq with queue empty -> count stays 0, pointers unchanged; a subsequent push/pop returns the correct word.
- Queue holding 3 entries with overflow=1, reset asserted one cycle -> count=0, empty=1, overflow=0, irq=0, head outputs 0 on the next cycle.
